// File: rtl/adder_operand_loader.sv
// Word-serial operand loader feeding the registered 66-bit adder: assembles A then B
// from IN_WIDTH-bit words and presents the pair. Optional sum tracker: LOADER_SUM_VALID_EN.
module adder_operand_loader #(
  parameter int unsigned ADDER_WIDTH = 66,
  parameter int unsigned IN_WIDTH    = 16,
  localparam int unsigned WORDS      = (ADDER_WIDTH + IN_WIDTH - 1) / IN_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic [ADDER_WIDTH-1:0] a,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   op_valid,
  input  logic                   op_ready
`ifdef LOADER_SUM_VALID_EN
  ,
  output logic                   sum_valid
`endif
);

  localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StPresent
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ADDER_WIDTH-1:0] asm_a_q, asm_a_d;
  logic [ADDER_WIDTH-1:0] asm_b_q, asm_b_d;
  logic [ADDER_WIDTH-1:0] a_q, a_d;
  logic [ADDER_WIDTH-1:0] b_q, b_d;

  logic [ADDER_WIDTH-1:0] word_mask;
  logic [ADDER_WIDTH-1:0] word_bits;
  logic [ADDER_WIDTH-1:0] merged_a;
  logic [ADDER_WIDTH-1:0] merged_b;
  logic                   last_word;

  // Each operand bit belongs to exactly one word; bits of the final word above the
  // operand width simply have no destination and are dropped.
  for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_bit
    assign word_mask[i] = (cnt_q == CntW'(i / IN_WIDTH));
    assign word_bits[i] = in_data[i % IN_WIDTH];
  end

  assign merged_a  = (asm_a_q & ~word_mask) | (word_bits & word_mask);
  assign merged_b  = (asm_b_q & ~word_mask) | (word_bits & word_mask);
  assign last_word = (cnt_q == CntW'(WORDS - 1));

  assign in_ready = (state_q != StPresent);
  assign op_valid = (state_q == StPresent);
  assign a        = a_q;
  assign b        = b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_a_d = asm_a_q;
    asm_b_d = asm_b_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StLoadA: begin
        if (in_valid) begin
          asm_a_d = merged_a;
          if (last_word) begin
            cnt_d   = '0;
            state_d = StLoadB;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StLoadB: begin
        if (in_valid) begin
          asm_b_d = merged_b;
          if (last_word) begin
            cnt_d   = '0;
            state_d = StPresent;
            a_d     = asm_a_q;
            b_d     = merged_b;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPresent: begin
        if (op_ready) state_d = StLoadA;
      end
      default: state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLoadA;
      cnt_q   <= '0;
      asm_a_q <= '0;
      asm_b_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_a_q <= asm_a_d;
      asm_b_q <= asm_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifdef LOADER_SUM_VALID_EN
  // Mirrors the adder's a_reg stage followed by its sum register.
  logic fire_q;
  logic sum_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q      <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      fire_q      <= op_valid && op_ready;
      sum_valid_q <= fire_q;
    end
  end

  assign sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_adder_operand_loader.sv
// Scoreboard bench for adder_operand_loader: directed word streams push expected pairs,
// a negedge monitor pops and compares on every fire.
module tb_adder_operand_loader;

  localparam int unsigned AW = 66;
  localparam int unsigned IW = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic          op_valid;
  logic          op_ready;
`ifdef LOADER_SUM_VALID_EN
  logic          sum_valid;
`endif

  adder_operand_loader #(
    .ADDER_WIDTH(AW),
    .IN_WIDTH   (IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .a        (a),
    .b        (b),
    .op_valid (op_valid),
    .op_ready (op_ready)
`ifdef LOADER_SUM_VALID_EN
    ,
    .sum_valid(sum_valid)
`endif
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  pair_t sb[$];
  int    fire_cyc[$];
  int    first_xfer;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every fire pops one expected pair.
  always @(negedge clk) begin
    if (op_valid === 1'b1 && op_ready === 1'b1) begin
      fire_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_fire", {{(AW-1){1'b0}}, op_valid}, '0);
      end else begin
        pair_t e;
        e = sb.pop_front();
        chk("fire_a", a, e.a);
        chk("fire_b", b, e.b);
      end
    end
  end

`ifdef LOADER_SUM_VALID_EN
  logic h1 = 1'b0;
  logic h2 = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      if (h2) chk("sum_valid", {{(AW-1){1'b0}}, sum_valid}, {{(AW-1){1'b0}}, 1'b1});
      h2 = h1;
      h1 = (op_valid === 1'b1 && op_ready === 1'b1);
    end
  end
`endif

  task automatic send_word(input logic [IW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        $display("FAIL in_ready_timeout: in_ready stayed %b, expected 1", in_ready);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "in_ready timeout");
      end
    end
    first_xfer = (first_xfer < 0) ? cyc : first_xfer;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Word 0 (A LSW) is the most-significant field of ws.
  task automatic send_pair(input logic [10*IW-1:0] ws, input logic [AW-1:0] ea,
                           input logic [AW-1:0] eb, input bit bubbles);
    pair_t e;
    e.a = ea;
    e.b = eb;
    sb.push_back(e);
    for (int k = 0; k < 10; k++) begin
      send_word(ws[(9-k)*IW +: IW]);
      if (bubbles && k < 9) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_fires(input int target);
    int n;
    n = 0;
    while (fire_cyc.size() < target && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fire_count", AW'(fire_cyc.size()), AW'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    op_ready   = 1'b1;
    first_xfer = -1;
    do_reset();
    @(negedge clk);
    chk("rst_a", a, '0);
    chk("rst_b", b, '0);
    chk("rst_op_valid", AW'(op_valid), '0);
    chk("rst_in_ready", AW'(in_ready), AW'(1));
    @(posedge clk);
    #1;

    // Carry-chain pair, then final-word truncation.
    send_pair({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003,
               16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
              66'h3_FFFF_FFFF_FFFF_FFFF, 66'h1, 1'b0);
    wait_fires(1);
    @(negedge clk);
    chk("one_cycle_op_valid", AW'(op_valid), '0);
    @(posedge clk);
    #1;
    send_pair({16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hFFFF,
               16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002},
              66'h3_DEF0_9ABC_5678_1234, 66'h2_0000_0000_0000_0000, 1'b0);
    wait_fires(2);

    // Back-to-back: three pairs with in_valid held high.
    n0 = fire_cyc.size();
    send_pair({16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0001,
               16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0002},
              66'h1_4444_3333_2222_1111, 66'h2_DDDD_CCCC_BBBB_AAAA, 1'b0);
    send_pair({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
              66'h0, 66'h3_FFFF_FFFF_FFFF_FFFF, 1'b0);
    send_pair({16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h0004,
               16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hF0F0, 16'h0000},
              66'h0_8000_0000_0000_8000, 66'h0_F0F0_0F0F_F0F0_0F0F, 1'b0);
    wait_fires(n0 + 3);
    chk("b2b_gap1", AW'(fire_cyc[n0+1] - fire_cyc[n0]), AW'(11));
    chk("b2b_gap2", AW'(fire_cyc[n0+2] - fire_cyc[n0+1]), AW'(11));

    // Backpressure: hold op_ready low for 5 cycles in PRESENT.
    op_ready = 1'b0;
    send_pair({16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0001,
               16'h0505, 16'h0606, 16'h0707, 16'h0808, 16'h0003},
              66'h1_0404_0303_0202_0101, 66'h3_0808_0707_0606_0505, 1'b0);
    n0 = fire_cyc.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", AW'(in_ready), '0);
      chk("bp_op_valid", AW'(op_valid), AW'(1));
      chk("bp_a", a, 66'h1_0404_0303_0202_0101);
      chk("bp_b", b, 66'h3_0808_0707_0606_0505);
      @(posedge clk);
      #1;
    end
    op_ready = 1'b1;
    wait_fires(n0 + 1);
    chk("bp_fire_cycle", AW'(fire_cyc[n0] - (cyc - 1)), '0);
    @(negedge clk);
    chk("bp_in_ready_after", AW'(in_ready), AW'(1));
    @(posedge clk);
    #1;

    // Bubbles between every word: word 9 in cycle c0+18, op_valid in cycle c0+19.
    first_xfer = -1;
    n0 = fire_cyc.size();
    send_pair({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003,
               16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
              66'h3_FFFF_FFFF_FFFF_FFFF, 66'h1, 1'b1);
    wait_fires(n0 + 1);
    chk("bubble_latency", AW'(fire_cyc[n0] - first_xfer), AW'(19));

    // Reset after three A words discards them.
    send_word(16'hDEAD);
    send_word(16'hBEEF);
    send_word(16'hCAFE);
    do_reset();
    @(negedge clk);
    chk("midrst_in_ready", AW'(in_ready), AW'(1));
    chk("midrst_a", a, '0);
    @(posedge clk);
    #1;
    n0 = fire_cyc.size();
    send_pair({16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h0001},
              66'h5, 66'h1_0000_0000_0000_0007, 1'b0);
    wait_fires(n0 + 1);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", AW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
